// File: rtl/stack_mem_pkg.sv
// rtl/stack_mem_pkg.sv - shared types and constants for the stack memory port
package stack_mem_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    localparam logic [7:0] STACK_TOP_DEF   = 8'hFF;
    localparam logic [7:0] STACK_LIMIT_DEF = 8'hC0;

endpackage

// File: rtl/sp_reg.sv
// rtl/sp_reg.sv - stack pointer register with load/inc/dec controls
module sp_reg #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VAL = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic              dec_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] sp_o,
    output logic [ADDR_W-1:0] sp_minus1_o
);

    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] sp_d;

    // Controls are expected one-hot; load wins if several are raised.
    always_comb begin
        sp_d = sp_q;
        if (load_i) begin
            sp_d = load_val_i;
        end else if (inc_i) begin
            sp_d = sp_q + ADDR_W'(1);
        end else if (dec_i) begin
            sp_d = sp_q - ADDR_W'(1);
        end
    end

    // SP state; reset leaves the stack empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= RESET_VAL;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp_o        = sp_q;
    assign sp_minus1_o = sp_q - ADDR_W'(1);

endmodule

// File: rtl/stack_mem_port.sv
// rtl/stack_mem_port.sv - stage-4 data memory access with stack pointer (option: STACK_BOUND_CHECK_EN)
module stack_mem_port
    import stack_mem_pkg::*;
#(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] STACK_TOP   = STACK_TOP_DEF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WR,
    input  logic              RD,
    input  logic              DSP,
    input  logic              ISP,
    input  logic              LSP,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              stall,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] sp_out,
    output logic              cmd_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef STACK_BOUND_CHECK_EN
    ,
    output logic              sp_fault
`endif
);

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              cmd_err_q, cmd_err_d;
    logic              pend_inc_q, pend_inc_d;
    logic              pend_dec_q, pend_dec_d;

    logic              sp_load, sp_inc, sp_dec;
    logic [ADDR_W-1:0] sp, sp_minus1;
    logic              req_blocked;

    sp_reg #(
        .ADDR_W    (ADDR_W),
        .RESET_VAL (STACK_TOP)
    ) u_sp_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (sp_load),
        .inc_i       (sp_inc),
        .dec_i       (sp_dec),
        .load_val_i  (data_in[ADDR_W-1:0]),
        .sp_o        (sp),
        .sp_minus1_o (sp_minus1)
    );

`ifdef STACK_BOUND_CHECK_EN
    logic sp_fault_q, sp_fault_d;

    // A push into a full stack or a pop from an empty one is refused before issue.
    always_comb begin
        req_blocked = (WR && DSP && (sp == STACK_LIMIT)) ||
                      (RD && !WR && ISP && !DSP && (sp == STACK_TOP));
        sp_fault_d  = sp_fault_q || ((state_q == S_IDLE) && req_blocked);
    end

    // Fault flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_fault_q <= 1'b0;
        end else begin
            sp_fault_q <= sp_fault_d;
        end
    end

    assign sp_fault = sp_fault_q;
`else
    // The limit only matters when bound checking is built in.
    localparam logic [ADDR_W-1:0] UNUSED_LIMIT = STACK_LIMIT;
    assign req_blocked = 1'b0;
`endif

    // Next-state: issue in IDLE, complete on ack in BUSY.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        cmd_err_d   = 1'b0;
        pend_inc_d  = pend_inc_q;
        pend_dec_d  = pend_dec_q;
        sp_load     = 1'b0;
        sp_inc      = 1'b0;
        sp_dec      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (WR || RD) begin
                    // A simultaneous WR/RD keeps the write and flags the conflict.
                    cmd_err_d = WR && RD;
                    if (!req_blocked) begin
                        state_d     = S_BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = WR ? DIR_WR : DIR_RD;
                        mem_addr_d  = DSP ? sp_minus1 : (ISP ? sp : addr_in);
                        mem_wdata_d = data_in;
                        pend_dec_d  = DSP;
                        pend_inc_d  = ISP && !DSP;
                    end
                end else if (LSP) begin
                    sp_load = 1'b1;
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    sp_inc    = pend_inc_q;
                    sp_dec    = pend_dec_q;
                    if (mem_we_q == DIR_RD) begin
                        rd_data_d  = mem_rdata;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and memory-port registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            pend_inc_q  <= 1'b0;
            pend_dec_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            cmd_err_q   <= cmd_err_d;
            pend_inc_q  <= pend_inc_d;
            pend_dec_q  <= pend_dec_d;
        end
    end

    assign stall     = (state_q == S_BUSY);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign cmd_err   = cmd_err_q;
    assign sp_out    = sp;

endmodule
